// File: rtl/uart_master_cmd_tx.sv
// Host-side UART command initiator: packs one WR/RD command into a 72-bit frame
// and shifts it out LSB first with start, optional even parity and stop bits.
module uart_master_cmd_tx #(
   parameter int CLOCK       = 100_000_000,
   parameter int BAUD_RATE   = 115_200,
   parameter int DATA_BITS   = 72,
   parameter int STOP_BITS   = 1,
   parameter int PARITY_BITS = 0
) (
   input  logic        aclk,
   input  logic        areset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_wr,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_data,
   output logic        uart_tx,
   output logic        busy,
   output logic        frame_done
);

   localparam int CLKS_PER_BIT = CLOCK / BAUD_RATE;
   localparam int BW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [6:0]    DATA_LAST = 7'(DATA_BITS - 1);
   localparam logic [6:0]    STOP_LAST = 7'(STOP_BITS - 1);
   localparam logic [4:0]    CODE_WR   = 5'b11100;
   localparam logic [4:0]    CODE_RD   = 5'b10101;

   typedef struct packed {
      logic [4:0]  code;
      logic [31:0] addr;
      logic [31:0] data;
      logic [2:0]  pad;
   } frame_t;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t        state, state_n;
   logic [BW-1:0] baud_cnt, baud_n;
   logic [6:0]    bit_cnt, bit_n;
   logic [71:0]   shift_reg, shift_n;
   logic          parity, parity_n;
   logic          tx_n;
   logic          baud_done;
   frame_t        cmd_frame;

   // Reads carry a zero data field regardless of cmd_data.
   always_comb begin
      cmd_frame.code = cmd_wr ? CODE_WR : CODE_RD;
      cmd_frame.addr = cmd_addr;
      cmd_frame.data = cmd_wr ? cmd_data : 32'h0;
      cmd_frame.pad  = 3'b000;
   end

   assign baud_done = (baud_cnt == BAUD_LAST);
   assign cmd_ready = (state == IDLE);
   assign busy      = ~cmd_ready;

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state     <= IDLE;
         baud_cnt  <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
         parity    <= 1'b0;
         uart_tx   <= 1'b1;
      end else begin
         state     <= state_n;
         baud_cnt  <= baud_n;
         bit_cnt   <= bit_n;
         shift_reg <= shift_n;
         parity    <= parity_n;
         uart_tx   <= tx_n;
      end
   end

   // tx_n is the line level for the cycle after this one, so the output
   // register always lines up with the state it belongs to.
   always_comb begin
      state_n    = state;
      baud_n     = baud_cnt;
      bit_n      = bit_cnt;
      shift_n    = shift_reg;
      parity_n   = parity;
      tx_n       = uart_tx;
      frame_done = 1'b0;

      case (state)
         IDLE: begin
            tx_n = 1'b1;
            if (cmd_valid) begin
               shift_n  = cmd_frame;
               parity_n = ^cmd_frame;
               baud_n   = '0;
               bit_n    = '0;
               tx_n     = 1'b0;
               state_n  = START;
            end
         end

         START: begin
            if (baud_done) begin
               baud_n  = '0;
               tx_n    = shift_reg[0];
               state_n = DATA;
            end else begin
               baud_n = baud_cnt + BW'(1);
            end
         end

         DATA: begin
            if (baud_done) begin
               baud_n  = '0;
               shift_n = shift_reg >> 1;
               if (bit_cnt == DATA_LAST) begin
                  bit_n = '0;
                  if (PARITY_BITS != 0) begin
                     tx_n    = parity;
                     state_n = PARITY;
                  end else begin
                     tx_n    = 1'b1;
                     state_n = STOP;
                  end
               end else begin
                  bit_n = bit_cnt + 7'd1;
                  tx_n  = shift_reg[1];
               end
            end else begin
               baud_n = baud_cnt + BW'(1);
            end
         end

         PARITY: begin
            if (baud_done) begin
               baud_n  = '0;
               tx_n    = 1'b1;
               state_n = STOP;
            end else begin
               baud_n = baud_cnt + BW'(1);
            end
         end

         STOP: begin
            tx_n = 1'b1;
            if (baud_done) begin
               baud_n = '0;
               if (bit_cnt == STOP_LAST) begin
                  bit_n      = '0;
                  frame_done = 1'b1;
                  state_n    = IDLE;
               end else begin
                  bit_n = bit_cnt + 7'd1;
               end
            end else begin
               baud_n = baud_cnt + BW'(1);
            end
         end

         default: begin
            state_n = IDLE;
            tx_n    = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_master_cmd_tx.sv
// Bench for uart_master_cmd_tx: instance 0 (no parity, 1 stop) and instance 1
// (even parity, 2 stops), both at 10 clocks per bit.
module tb_uart_master_cmd_tx;

   localparam int N = 10;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [71:0] frame;
   } vec_t;

   logic        aclk = 1'b0;
   logic        areset;
   logic        cv [2];
   logic        cw [2];
   logic [31:0] ca [2];
   logic [31:0] cd [2];
   logic        tx [2];
   logic        rdy [2];
   logic        bsy [2];
   logic        fd [2];

   int vectors = 0;
   int miscompares = 0;

   vec_t vt [4];
   vec_t sq [3];

   always #5 aclk = ~aclk;

   uart_master_cmd_tx #(.CLOCK(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(72),
                        .STOP_BITS(1), .PARITY_BITS(0)) dut_a (
      .aclk(aclk), .areset(areset), .cmd_valid(cv[0]), .cmd_ready(rdy[0]),
      .cmd_wr(cw[0]), .cmd_addr(ca[0]), .cmd_data(cd[0]), .uart_tx(tx[0]),
      .busy(bsy[0]), .frame_done(fd[0]));

   uart_master_cmd_tx #(.CLOCK(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(72),
                        .STOP_BITS(2), .PARITY_BITS(1)) dut_b (
      .aclk(aclk), .areset(areset), .cmd_valid(cv[1]), .cmd_ready(rdy[1]),
      .cmd_wr(cw[1]), .cmd_addr(ca[1]), .cmd_data(cd[1]), .uart_tx(tx[1]),
      .busy(bsy[1]), .frame_done(fd[1]));

   // Reference frame packing straight from the command format.
   function automatic logic [71:0] mk_frame(input logic wr, input logic [31:0] addr,
                                            input logic [31:0] data);
      return {wr ? 5'b11100 : 5'b10101, addr, wr ? data : 32'h0, 3'b000};
   endfunction

   // Expected line level at cycle i of a frame (cycle 0 = first start-bit cycle).
   function automatic logic exp_line(input logic [71:0] fr, input int par, input int i);
      int b;
      b = i / N;
      if (b == 0) return 1'b0;
      if (b <= 72) return fr[b-1];
      if (par != 0 && b == 73) return ^fr;
      return 1'b1;
   endfunction

   task automatic chk(input bit ok, input string nm, input logic [71:0] got,
                      input logic [71:0] want);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL %s: got %h want %h", nm, got, want);
      end
   endtask

   // Issue sq[0..n-1] on instance k with cmd_valid held; fields are scrambled
   // while the block is busy to show they are ignored.
   task automatic send_seq(input int k, input int n);
      int j;
      j = 0;
      for (int t = 0; t < 5000 && j < n; t++) begin
         @(negedge aclk);
         if (rdy[k]) begin
            cv[k] = 1'b1;
            cw[k] = sq[j].wr;
            ca[k] = sq[j].addr;
            cd[k] = sq[j].data;
            @(posedge aclk);
            j++;
         end else begin
            cw[k] = 1'($urandom);
            ca[k] = $urandom;
            cd[k] = $urandom;
         end
      end
      #1;
      cv[k] = 1'b0;
      cw[k] = 1'($urandom);
      ca[k] = $urandom;
      cd[k] = $urandom;
      chk(j == n, "send_timeout", 72'(j), 72'(n));
   endtask

   // Watch one whole frame on instance k plus the idle cycle that follows it.
   task automatic check_frame(input int k, input logic [71:0] fr, input int maxw,
                              input string nm);
      int par, stops, len, errs, first;
      bit seen;
      logic [71:0] dec;
      logic pb;
      par   = (k == 1) ? 1 : 0;
      stops = (k == 1) ? 2 : 1;
      len   = (73 + par + stops) * N;
      errs  = 0;
      first = -1;
      dec   = '0;
      pb    = 1'b0;
      seen  = 1'b0;
      for (int w = 0; w < maxw; w++) begin
         @(negedge aclk);
         if (tx[k] === 1'b0) begin
            seen = 1'b1;
            break;
         end
      end
      chk(seen, {nm, "_start"}, 72'(seen), 72'(1));
      if (!seen) return;
      for (int i = 0; i < len; i++) begin
         if (i > 0) @(negedge aclk);
         if (tx[k] !== exp_line(fr, par, i) || rdy[k] !== 1'b0 || bsy[k] !== 1'b1 ||
             fd[k] !== (i == len - 1)) begin
            if (errs == 0) first = i;
            errs++;
         end
         if (i % N == N / 2 && i / N >= 1 && i / N <= 72) dec[i/N-1] = tx[k];
         if (i % N == N / 2 && i / N == 73) pb = tx[k];
      end
      chk(dec == fr, {nm, "_frame"}, dec, fr);
      chk(errs == 0, {nm, "_wave_errs_first_at"}, 72'(first), 72'(0));
      if (par != 0) chk(pb == ^fr, {nm, "_parity"}, 72'(pb), 72'(^fr));
      @(negedge aclk);
      chk(tx[k] === 1'b1 && rdy[k] === 1'b1 && bsy[k] === 1'b0 && fd[k] === 1'b0,
          {nm, "_idle"}, 72'({tx[k], rdy[k], bsy[k], fd[k]}), 72'(4'b1100));
   endtask

   task automatic one_cmd(input int k, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [71:0] fr, input string nm);
      sq[0] = '{wr, addr, data, fr};
      fork
         send_seq(k, 1);
         check_frame(k, fr, 100, nm);
      join
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic wr;
      logic [31:0] a, d;
      bit ok;

      vt[0] = '{1'b1, 32'h4000_0010, 32'hDEAD_BEEF, {5'b11100, 32'h4000_0010, 32'hDEAD_BEEF, 3'b000}};
      vt[1] = '{1'b0, 32'h0000_0004, 32'hFFFF_FFFF, {5'b10101, 32'h0000_0004, 32'h0000_0000, 3'b000}};
      vt[2] = '{1'b1, 32'h0000_0000, 32'h0000_0000, {5'b11100, 32'h0000_0000, 32'h0000_0000, 3'b000}};
      vt[3] = '{1'b0, 32'hFFFF_FFFF, 32'h1234_5678, {5'b10101, 32'hFFFF_FFFF, 32'h0000_0000, 3'b000}};

      for (int k = 0; k < 2; k++) begin
         cv[k] = 1'b0; cw[k] = 1'b0; ca[k] = '0; cd[k] = '0;
      end
      areset = 1'b1;
      repeat (2) @(negedge aclk);
      for (int k = 0; k < 2; k++)
         chk(tx[k] === 1'b1 && rdy[k] === 1'b1 && bsy[k] === 1'b0 && fd[k] === 1'b0,
             "reset_state", 72'({tx[k], rdy[k], bsy[k], fd[k]}), 72'(4'b1100));
      #2 areset = 1'b0;

      // Directed table on both line formats.
      for (int i = 0; i < 4; i++)
         one_cmd(0, vt[i].wr, vt[i].addr, vt[i].data, vt[i].frame, $sformatf("vecA%0d", i));
      for (int i = 0; i < 2; i++)
         one_cmd(1, vt[i].wr, vt[i].addr, vt[i].data, vt[i].frame, $sformatf("vecB%0d", i));

      // Random commands against the reference packing.
      for (int i = 0; i < 6; i++) begin
         wr = 1'($urandom); a = $urandom; d = $urandom;
         one_cmd(0, wr, a, d, mk_frame(wr, a, d), $sformatf("randA%0d", i));
      end
      for (int i = 0; i < 2; i++) begin
         wr = 1'($urandom); a = $urandom; d = $urandom;
         one_cmd(1, wr, a, d, mk_frame(wr, a, d), $sformatf("randB%0d", i));
      end

      // Held cmd_valid: three frames with exactly one idle cycle between them.
      for (int i = 0; i < 3; i++) begin
         wr = 1'($urandom); a = $urandom; d = $urandom;
         sq[i] = '{wr, a, d, mk_frame(wr, a, d)};
      end
      fork
         send_seq(0, 3);
         begin
            check_frame(0, sq[0].frame, 100, "b2b0");
            check_frame(0, sq[1].frame, 1, "b2b1");
            check_frame(0, sq[2].frame, 1, "b2b2");
         end
      join

      // Asynchronous reset in the middle of data bit 30.
      sq[0] = '{1'b1, 32'hA5A5_0F0F, 32'h0123_4567, mk_frame(1'b1, 32'hA5A5_0F0F, 32'h0123_4567)};
      fork
         send_seq(0, 1);
         begin
            ok = 1'b0;
            for (int w = 0; w < 100 && !ok; w++) begin
               @(negedge aclk);
               ok = (tx[0] === 1'b0);
            end
            chk(ok, "abort_start", 72'(ok), 72'(1));
            repeat ((1 + 30) * N + 4) @(negedge aclk);
            #2 areset = 1'b1;
            #1 chk(tx[0] === 1'b1 && rdy[0] === 1'b1 && bsy[0] === 1'b0,
                   "abort_async", 72'({tx[0], rdy[0], bsy[0]}), 72'(3'b110));
            ok = 1'b1;
            repeat (5) begin
               @(negedge aclk);
               ok &= (tx[0] === 1'b1 && fd[0] === 1'b0 && rdy[0] === 1'b1);
            end
            chk(ok, "abort_hold", 72'(ok), 72'(1));
            #2 areset = 1'b0;
         end
      join
      ok = 1'b1;
      repeat (3 * N) begin
         @(negedge aclk);
         ok &= (tx[0] === 1'b1 && fd[0] === 1'b0 && bsy[0] === 1'b0);
      end
      chk(ok, "abort_no_done", 72'(ok), 72'(1));
      one_cmd(0, vt[0].wr, vt[0].addr, vt[0].data, vt[0].frame, "after_abort");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
